// File: rtl/onewire_txn_master.sv
`default_nettype none
// onewire_txn_master: open-drain 1-Wire master; per start pulse runs an optional
// reset/presence phase, tx_len byte writes and rx_len byte reads (LSB first).
module onewire_txn_master #(
  parameter int T_RSTL    = 48000,
  parameter int T_RSTH    = 48000,
  parameter int T_PDS     = 7000,
  parameter int T_SLOT    = 6000,
  parameter int T_LOW0    = 5500,
  parameter int T_LOW1    = 600,
  parameter int T_RDS     = 1300,
  parameter int T_REC     = 100,
  parameter int MAX_BYTES = 8,
  localparam int LW = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          skip_rst,
  input  logic [LW-1:0] tx_len,
  input  logic [LW-1:0] rx_len,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          presence,
  inout  wire           ow_io
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = imax(imax(T_RSTL, T_RSTH), T_SLOT + T_REC);
  localparam int CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] C_RSTL_END = CW'(T_RSTL - 1);
  localparam logic [CW-1:0] C_RSTH_END = CW'(T_RSTH - 1);
  localparam logic [CW-1:0] C_PDS      = CW'(T_PDS);
  localparam logic [CW-1:0] C_SLOT_END = CW'(T_SLOT + T_REC - 1);
  localparam logic [CW-1:0] C_LOW0     = CW'(T_LOW0);
  localparam logic [CW-1:0] C_LOW1     = CW'(T_LOW1);
  localparam logic [CW-1:0] C_RDS      = CW'(T_RDS);
  localparam logic [LW-1:0] C_MAXB     = LW'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_LOW = 3'd1,
    RST_REL = 3'd2,
    TX_GET  = 3'd3,
    TX_SLOT = 3'd4,
    RX_SLOT = 3'd5,
    FIN     = 3'd6
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [LW-1:0] tx_cnt, rx_cnt, tx_len_q, rx_len_q;
  logic [7:0]    tx_sh, rx_sh;
  logic [1:0]    sync_ff;
  logic          sync_in;
  logic          pull, cnt_clr, slot_end, tx_left, rx_last;

  assign ow_io    = pull ? 1'b0 : 1'bz;
  assign sync_in  = sync_ff[1];
  assign slot_end = (cnt == C_SLOT_END);
  assign tx_left  = (tx_cnt != tx_len_q);
  assign rx_last  = ((rx_cnt + LW'(1)) == rx_len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pull       = 1'b0;
    wr_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        cnt_clr = 1'b1;
        if (start) state_next = skip_rst ? TX_GET : RST_LOW;
      end
      RST_LOW: begin
        pull = 1'b1;
        if (cnt == C_RSTL_END) begin
          cnt_clr    = 1'b1;
          state_next = RST_REL;
        end
      end
      RST_REL: begin
        if (cnt == C_RSTH_END) begin
          cnt_clr = 1'b1;
          // With nothing to transfer, end right at the close of the presence window.
          if (!presence || (tx_len_q == '0 && rx_len_q == '0)) state_next = FIN;
          else                                                  state_next = TX_GET;
        end
      end
      TX_GET: begin
        cnt_clr = 1'b1;
        if (tx_left) begin
          wr_ready = 1'b1;
          if (wr_valid) state_next = TX_SLOT;
        end else if (rx_len_q != '0) begin
          state_next = RX_SLOT;
        end else begin
          state_next = FIN;
        end
      end
      TX_SLOT: begin
        pull = (cnt < (tx_sh[0] ? C_LOW1 : C_LOW0));
        if (slot_end) begin
          cnt_clr = 1'b1;
          if (bit_cnt == 3'd7) state_next = TX_GET;
        end
      end
      RX_SLOT: begin
        pull = (cnt < C_LOW1);
        if (slot_end) begin
          cnt_clr = 1'b1;
          if (bit_cnt == 3'd7 && rx_last) state_next = FIN;
        end
      end
      FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff  <= 2'b11;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      tx_len_q <= '0;
      rx_len_q <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      presence <= 1'b0;
    end else begin
      sync_ff  <= {sync_ff[0], ow_io};
      rd_valid <= 1'b0;
      // Saturating timer: a phase can never see the count wrap back to zero.
      if (cnt_clr)                  cnt <= '0;
      else if (cnt != {CW{1'b1}})   cnt <= cnt + CW'(1);

      if (state == IDLE && start) begin
        tx_len_q <= (tx_len > C_MAXB) ? C_MAXB : tx_len;
        rx_len_q <= (rx_len > C_MAXB) ? C_MAXB : rx_len;
        tx_cnt   <= '0;
        rx_cnt   <= '0;
        bit_cnt  <= '0;
      end

      if (state == RST_REL && cnt == C_PDS) presence <= ~sync_in;

      if (state == TX_GET && wr_ready && wr_valid) begin
        tx_sh  <= wr_data;
        tx_cnt <= tx_cnt + LW'(1);
      end

      if (state == TX_SLOT && slot_end) begin
        tx_sh   <= {1'b0, tx_sh[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (state == RX_SLOT) begin
        if (cnt == C_RDS) rx_sh <= {sync_in, rx_sh[7:1]};
        if (slot_end) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rd_data  <= rx_sh;
            rd_valid <= 1'b1;
            rx_cnt   <= rx_cnt + LW'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onewire_txn_master.sv
`default_nettype none
// tb_onewire_txn_master: scoreboard bench with a behavioural 1-Wire slave;
// timings are scaled down 20x so the whole run stays short.
module tb_onewire_txn_master;

  localparam int T_RSTL    = 2400;
  localparam int T_RSTH    = 2400;
  localparam int T_PDS     = 350;
  localparam int T_SLOT    = 300;
  localparam int T_LOW0    = 275;
  localparam int T_LOW1    = 30;
  localparam int T_RDS     = 65;
  localparam int T_REC     = 5;
  localparam int MAX_BYTES = 8;
  localparam int LW        = $clog2(MAX_BYTES + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          skip_rst = 1'b0;
  logic [LW-1:0] tx_len = '0;
  logic [LW-1:0] rx_len = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_valid = 1'b0;
  wire           wr_ready;
  wire  [7:0]    rd_data;
  wire           rd_valid, busy, done, presence;
  wire           ow_io;

  pullup (ow_io);

  onewire_txn_master #(
    .T_RSTL(T_RSTL), .T_RSTH(T_RSTH), .T_PDS(T_PDS), .T_SLOT(T_SLOT),
    .T_LOW0(T_LOW0), .T_LOW1(T_LOW1), .T_RDS(T_RDS), .T_REC(T_REC),
    .MAX_BYTES(MAX_BYTES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .skip_rst(skip_rst),
    .tx_len(tx_len), .rx_len(rx_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .presence(presence), .ow_io(ow_io)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural slave: presence pulse after a long master low, and read-0 answers
  // that start just after the master releases so both pulses stay distinguishable.
  logic        slave_present = 1'b0;
  logic        rx_mode = 1'b0;
  logic [63:0] rx_bits = '0;
  int          bit_idx = 0;
  logic        line_q = 1'b1, master_low = 1'b0, rd_zero = 1'b0;
  int          fall_cyc = 0;
  int          pres_start = -100000;
  wire         slave_pull = (cyc >= pres_start && cyc < pres_start + 400) ||
                            (rd_zero && cyc >= fall_cyc + 33 && cyc < fall_cyc + 75);
  assign ow_io = slave_pull ? 1'b0 : 1'bz;

  always @(posedge clk) begin
    line_q <= ow_io;
    if (!rx_mode) bit_idx <= 0;
    if (line_q && !ow_io) begin
      master_low <= !slave_pull;
      if (!slave_pull) begin
        fall_cyc <= cyc;
        if (rx_mode && bit_idx < 64) begin
          rd_zero <= ~rx_bits[bit_idx];
          bit_idx <= bit_idx + 1;
        end else begin
          rd_zero <= 1'b0;
        end
      end
    end
    if (!line_q && ow_io && master_low && slave_present && (cyc - fall_cyc) > 1000)
      pres_start <= cyc + 15;
  end

  // Scoreboard queues filled by stimulus, drained by the monitors below.
  int         exp_low[$];
  logic [7:0] exp_rd[$];
  logic       exp_done[$];
  logic       chk_low = 1'b1;
  logic       lm_q = 1'b1, lm_master = 1'b0;
  int         low_start = 0, rel_cyc = 0, hs_cnt = 0;

  always @(negedge clk) begin
    lm_q <= ow_io;
    if (lm_q && !ow_io) begin
      low_start <= cyc;
      lm_master <= !slave_pull;
    end
    if (!lm_q && ow_io && lm_master) begin
      rel_cyc <= cyc;
      if (chk_low) begin
        if (exp_low.size() == 0) check("unexpected_low_pulse", cyc - low_start, 0);
        else                     check("low_width", cyc - low_start, exp_low.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_rd.size() == 0) check("unexpected_rd_valid", 1, 0);
      else                    check("rd_data", rd_data, exp_rd.pop_front());
    end
  end

  always @(negedge clk) begin
    if (done) begin
      if (exp_done.size() == 0) check("unexpected_done", 1, 0);
      else begin
        check("presence_at_done", presence, exp_done.pop_front());
        check("busy_at_done", busy, 0);
      end
    end
  end

  always @(negedge clk) if (wr_valid && wr_ready) hs_cnt <= hs_cnt + 1;

  int start_cyc = 0;

  task automatic go(input logic skip, input int txl, input int rxl);
    @(posedge clk); #1;
    skip_rst  = skip;
    tx_len    = LW'(txl);
    rx_len    = LW'(rxl);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    for (int i = 0; i < 8; i++) exp_low.push_back(b[i] ? T_LOW1 : T_LOW0);
    repeat (gap) @(posedge clk);
    #1;
    wr_data  = b;
    wr_valid = 1'b1;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (wr_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (!ok) check("wr_ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input string name, input int limit, output int at);
    bit seen = 1'b0;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
    if (!seen) check(name, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic queues_empty(input string name);
    check({name, "_low_left"}, exp_low.size(), 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_done_left"}, exp_done.size(), 0);
  endtask

  initial begin
    int at, hs_base, falls;
    logic prev;

    #2 reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_presence", presence, 0);
    check("rst_line", ow_io, 1);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset/presence with an answering slave, no bytes.
    slave_present = 1'b1;
    exp_low.push_back(T_RSTL);
    exp_done.push_back(1'b1);
    go(1'b0, 0, 0);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    wait_done("t1_done_timeout", 6000, at);
    check("t1_release_to_done", at - rel_cyc, T_RSTH);
    queues_empty("t1");

    // 2: no slave; lengths nonzero, yet no slots and no handshakes.
    slave_present = 1'b0;
    hs_base = hs_cnt;
    exp_low.push_back(T_RSTL);
    exp_done.push_back(1'b0);
    wr_data  = 8'h99;
    wr_valid = 1'b1;
    go(1'b0, 1, 1);
    wait_done("t2_done_timeout", 6000, at);
    wr_valid = 1'b0;
    check("t2_busy_after_done", busy, 0);
    check("t2_handshakes", hs_cnt - hs_base, 0);
    queues_empty("t2");

    // Zero-length skip_rst transaction: done two cycles after start.
    exp_done.push_back(1'b0);
    go(1'b1, 0, 0);
    wait_done("t_zero_done_timeout", 10, at);
    check("t_zero_start_to_done", at - start_cyc, 2);
    queues_empty("t_zero");

    // 3: two write bytes, LSB first.
    hs_base = hs_cnt;
    exp_done.push_back(1'b0);
    go(1'b1, 2, 0);
    send_byte(8'hCC, 0);
    send_byte(8'h44, 0);
    wait_done("t3_done_timeout", 8000, at);
    check("t3_handshakes", hs_cnt - hs_base, 2);
    queues_empty("t3");

    // 4: two read bytes.
    rx_bits = {48'h0, 8'h3C, 8'hA5};
    rx_mode = 1'b1;
    for (int i = 0; i < 16; i++) exp_low.push_back(T_LOW1);
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h3C);
    exp_done.push_back(1'b0);
    go(1'b1, 0, 2);
    wait_done("t4_done_timeout", 8000, at);
    rx_mode = 1'b0;
    queues_empty("t4");

    // 5: long stall between write bytes.
    hs_base = hs_cnt;
    exp_done.push_back(1'b0);
    go(1'b1, 2, 0);
    send_byte(8'h0F, 0);
    repeat (5000) @(negedge clk);
    check("t5_line_idle_in_stall", ow_io, 1);
    check("t5_busy_in_stall", busy, 1);
    check("t5_wr_ready_in_stall", wr_ready, 1);
    send_byte(8'hF0, 5000);
    wait_done("t5_done_timeout", 8000, at);
    check("t5_handshakes", hs_cnt - hs_base, 2);
    queues_empty("t5");

    // rx_len above MAX_BYTES saturates to eight reads.
    rx_bits = {48'hFFFF_FFFF_FFFF, 8'h81, 8'h7E};
    rx_mode = 1'b1;
    for (int i = 0; i < 64; i++) exp_low.push_back(T_LOW1);
    exp_rd.push_back(8'h7E);
    exp_rd.push_back(8'h81);
    for (int i = 0; i < 6; i++) exp_rd.push_back(8'hFF);
    exp_done.push_back(1'b0);
    go(1'b1, 0, 15);
    wait_done("t_sat_done_timeout", 25000, at);
    rx_mode = 1'b0;
    queues_empty("t_sat");

    // 6: reset while the line is low in write slot 3.
    chk_low = 1'b0;
    go(1'b1, 1, 0);
    send_byte(8'h00, 0);
    falls = 0;
    prev  = ow_io;
    for (int i = 0; i < 5000 && falls < 4; i++) begin
      @(negedge clk);
      if (prev && !ow_io) falls++;
      prev = ow_io;
    end
    check("t6_slot3_reached", falls, 4);
    repeat (100) @(negedge clk);
    check("t6_line_low_before_reset", ow_io, 0);
    #1 reset = 1'b1;
    #1;
    check("t6_line_released_on_reset", ow_io, 1);
    check("t6_busy_on_reset", busy, 0);
    repeat (5) @(negedge clk);
    exp_low.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_rd_data_cleared", rd_data, 0);
    check("t6_presence_cleared", presence, 0);
    chk_low = 1'b1;
    exp_done.push_back(1'b0);
    go(1'b1, 1, 0);
    send_byte(8'hA5, 0);
    wait_done("t6_rerun_done_timeout", 5000, at);
    queues_empty("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
